// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the decryptor.
//   state_t        controller state encodings
//   sbox/inv_sbox  forward and inverse S-box lookups
//   rcon           key-schedule round constant, indexed 1..10
//   xtime/gmul     GF(2^8) helpers
//   sub_word       four forward S-box lookups on a 32-bit word
//   key_fwd/inv    one step of the forward / inverse key schedule
package aes_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, KEYEXP, ADDKEY, ROUND, FINAL, DONE} state_t;

   // Byte b of each table sits at bits [8*b +: 8] (ascending range).
   localparam logic [0:2047] SBOX_T = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [0:2047] INV_SBOX_T = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_T[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX_T[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // K_(r+1) from K_r; rc is Rcon[r+1].
   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // K_r from K_(r+1); rc is Rcon[r+1]. The new w3 feeds the SubWord term.
   function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n3 = k[31:0] ^ k[63:32];
      n2 = k[63:32] ^ k[95:64];
      n1 = k[95:64] ^ k[127:96];
      n0 = k[127:96] ^ sub_word({n3[23:0], n3[31:24]}) ^ {rc, 24'h0};
      return {n0, n1, n2, n3};
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational AES inverse S-box.
//   a  in  8  input byte
//   y  out 8  InvSubBytes of a
module aes_inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   assign y = inv_sbox(a);

endmodule

// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 inverse cipher, one round per clock.
//   clk     in  1    rising-edge clock
//   reset   in  1    asynchronous active-high reset
//   we      in  1    byte strobe, honoured only in IDLE/LOAD
//   Indata  in  8    16 ciphertext bytes then 16 key bytes, MSB first
//   busy    out 1    operation in progress
//   done    out 1    one-cycle completion pulse
//   out     out 128  plaintext, updated only on completion
module aes_decrypt
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [7:0]   Indata,
   output logic         busy,
   output logic         done,
   output logic [127:0] out
);

   state_t        state, state_nx;
   logic [4:0]    cnt;
   logic [3:0]    rnd;
   logic [127:0]  st, key;
   logic [127:0]  isr, isb, ark, imc, k_inv;

   // rnd is r during ROUND and 0 during FINAL, so Rcon[rnd+1] serves both.
   assign k_inv = key_inv(key, rcon(rnd + 4'd1));

   for (genvar c = 0; c < 4; c++) begin : g_isr
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign isr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
   end

   for (genvar i = 0; i < 16; i++) begin : g_isb
      aes_inv_sbox u_sb (.a(isr[8*i +: 8]), .y(isb[8*i +: 8]));
   end

   assign ark = isb ^ k_inv;

   for (genvar c = 0; c < 4; c++) begin : g_imc
      logic [7:0] a0, a1, a2, a3;
      assign a0 = ark[127-32*c -: 8];
      assign a1 = ark[119-32*c -: 8];
      assign a2 = ark[111-32*c -: 8];
      assign a3 = ark[103-32*c -: 8];
      assign imc[127-32*c -: 32] = {
         gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
         gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
         gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
         gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = we ? LOAD : IDLE;
         LOAD:    state_nx = (we && cnt == 5'd31) ? KEYEXP : LOAD;
         KEYEXP:  state_nx = (rnd == 4'd10) ? ADDKEY : KEYEXP;
         ADDKEY:  state_nx = ROUND;
         ROUND:   state_nx = (rnd == 4'd1) ? FINAL : ROUND;
         FINAL:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = state != IDLE && state != DONE;
      done = state == DONE;
   end

   // The ciphertext and key shift through {st, key} as one 256-bit register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         rnd <= '0;
         st  <= '0;
         key <= '0;
         out <= '0;
      end else begin
         case (state)
            IDLE, LOAD: if (we) begin
               {st, key} <= {st[119:0], key, Indata};
               cnt       <= (state == IDLE) ? 5'd1 : cnt + 5'd1;
               rnd       <= 4'd1;
            end
            KEYEXP: begin
               key <= key_fwd(key, rcon(rnd));
               rnd <= (rnd == 4'd10) ? 4'd9 : rnd + 4'd1;
            end
            ADDKEY: st <= st ^ key;
            ROUND: begin
               st  <= imc;
               key <= k_inv;
               rnd <= rnd - 4'd1;
            end
            FINAL: begin
               out <= ark;
               key <= k_inv;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 The block SHALL expose these ports (name, direction, width, meaning):
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 we  in  1  byte-load strobe; Indata accepted on each rising clk edge with we=1 while not busy.
REQ-005 Indata  in  8  serial load byte: 16 ciphertext bytes, then 16 cipher-key bytes.
REQ-006 busy  out  1  high from the first accepted byte until done is pulsed.
REQ-007 done  out  1  one-cycle pulse; out holds valid plaintext.
REQ-008 out  out  128  plaintext result, held until the next completion or reset.

Function
REQ-009 The block SHALL perform AES-128 decryption (FIPS-197 inverse cipher) only; the key is fixed at 16 bytes.
REQ-010 Byte order SHALL be first-received = most significant: ciphertext byte 0 lands in [127:120]; the key is loaded the same way.
REQ-011 The states SHALL be IDLE, LOAD, KEYEXP, ADDKEY, ROUND, FINAL and DONE.
REQ-012 IDLE -> LOAD on the first accepted byte, which is counted as byte 1.
REQ-013 LOAD SHALL use a 5-bit byte counter, advanced only on cycles with we=1; a we=0 gap pauses loading without loss of data.
REQ-014 LOAD -> KEYEXP on the edge accepting byte 32.
REQ-015 KEYEXP SHALL run the forward key schedule one round per cycle for 10 cycles, leaving round key 10 in the key register; Rcon = 01,02,04,08,10,20,40,80,1b,36.
REQ-016 ADDKEY (1 cycle) SHALL set state = ciphertext XOR round key 10.
REQ-017 ROUND SHALL take 9 cycles, r = 9 down to 1; each cycle: state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), K_r)).
REQ-018 In each ROUND cycle, K_r SHALL be derived from K_(r+1) by the inverse schedule: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon[r+1].
REQ-019 FINAL (1 cycle) SHALL compute out = AddRoundKey(InvSubBytes(InvShiftRows(state)), K_0), then go to DONE.
REQ-020 DONE SHALL assert done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle after the 21st rising edge following the edge that accepted byte 32.
REQ-022 we SHALL be ignored in KEYEXP, ADDKEY, ROUND, FINAL and DONE; bytes presented then are discarded.
REQ-023 out SHALL change only on the FINAL edge; intermediate round state is never visible on out.
REQ-024 A new load SHALL be accepted from IDLE on the cycle after DONE, with no dead cycle beyond DONE.
REQ-025 All datapath widths SHALL be exact (128-bit state and key, 4-bit round counter); no truncation or extension.

Reset
REQ-026 reset SHALL force IDLE, out=0, done=0, busy=0, and clear the byte counter, round counter, state register and key register, regardless of the current state.
REQ-027 Reset asserted mid-load or mid-round SHALL abort the operation; no done pulse is produced for it.
REQ-028 After reset deassertion, the first accepted we byte SHALL be treated as ciphertext byte 1.

Structure
REQ-029 Shared package aes_pkg SHALL hold the state encodings, the Rcon table, the forward S-box and inverse S-box tables as functions, and the GF(2^8) xtime/multiply helpers.
REQ-030 Sub-module aes_inv_sbox (8-bit in, 8-bit out, combinational) SHALL be instantiated 16 times for InvSubBytes.
REQ-031 The 4 forward S-box lookups for the key schedule SHALL use the aes_pkg function.
REQ-032 InvShiftRows and InvMixColumns SHALL be combinational logic inside aes_decrypt, using columns-major FIPS-197 byte mapping.

Verification
REQ-033 FIPS-197 C.1: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f -> out=00112233445566778899aabbccddeeff, done exactly 21 cycles after the last byte.
REQ-034 FIPS-197 App. B: ciphertext 3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c -> out=3243f6a8885a308d313198a2e0370734.
REQ-035 C.1 load with we held low for 3 cycles after bytes 7 and 20 -> same plaintext; done delayed by exactly 6 cycles.
REQ-036 Reset pulsed during ROUND r=5 -> out=0, no done pulse; an immediate reload of the App. B vector -> correct plaintext.
REQ-037 we toggled with random Indata throughout busy -> result unchanged; back-to-back C.1 then App. B loads starting the cycle after DONE -> both results correct, two done pulses.
